// File: rtl/pe_seq_if.sv
`default_nettype none
// ============================================================================
// Module     : pe_seq_if
// Description: Command, operand, result and PE drive/return signals for
//              pe_seq. The slave modport is the sequencer's view; the master
//              modport is the view of whatever surrounds it.
// Revision   : 1.0 - initial release
// ============================================================================
interface pe_seq_if #(
  parameter int LEN_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic             op_valid;
  logic             op_ready;
  logic [7:0]       op_a;
  logic [7:0]       op_b;
  logic [1:0]       pe_mode_o;
  logic [7:0]       pe_in_o;
  logic [7:0]       pe_filter_o;
  logic             pe_act_o;
  logic [7:0]       pe_out_i;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic             res_last;
  logic             busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, op_valid, op_a, op_b, pe_out_i, res_ready,
    output cmd_ready, op_ready, pe_mode_o, pe_in_o, pe_filter_o, pe_act_o,
           res_valid, res_data, res_last, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_len, op_valid, op_a, op_b, pe_out_i, res_ready,
    input  cmd_ready, op_ready, pe_mode_o, pe_in_o, pe_filter_o, pe_act_o,
           res_valid, res_data, res_last, busy
  );
endinterface
`default_nettype wire

// File: rtl/pe_seq.sv
`default_nettype none
// ============================================================================
// Module     : pe_seq
// Description: Command-driven sequencer for one processing element. Runs
//              weight LOAD, MAC and SA-pass operations by driving the PE
//              mode/data/activate lines and queues pe_out returns into a small
//              result FIFO presented as a valid/ready stream.
// Revision   : 1.0 - initial release
// ============================================================================
module pe_seq #(
  parameter int LEN_W   = 4,
  parameter int ACC_LAT = 1,
  parameter int FIFO_D  = 2
) (
  input  logic     clk,
  input  logic     rst,
  pe_seq_if.slave  bus
);

  localparam int AW = $clog2(FIFO_D);
  localparam int DW = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_END = DW'((ACC_LAT > 0) ? ACC_LAT - 1 : 0);
  localparam logic [AW:0]   DEPTH     = (AW+1)'(FIFO_D);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CAPL  = 3'd2,
    S_MAC   = 3'd3,
    S_DRAIN = 3'd4,
    S_CAPM  = 3'd5,
    S_SA    = 3'd6,
    S_RESP  = 3'd7
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic [DW-1:0]    drain_cnt;
  logic             inflight;
  logic             inflight_last;

  logic [8:0]       mem [FIFO_D];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic             has_space;
  logic             sa_space;
  logic             fire;
  logic             cmd_fire;
  logic             push;
  logic             pop;
  logic [7:0]       push_data;
  logic             push_last;

  assign has_space = (count < DEPTH);
  // An SA beat reserves a slot for the result that returns one cycle later.
  assign sa_space  = ((count + {{AW{1'b0}}, inflight}) < DEPTH);
  assign fire      = bus.op_valid && bus.op_ready;
  assign cmd_fire  = bus.cmd_valid && bus.cmd_ready;
  assign pop       = bus.res_valid && bus.res_ready;

  // Command is only taken in IDLE, and never while reset is held.
  assign bus.cmd_ready = rst && (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE) || (count != '0);

  // Operand acceptance per state.
  always_comb begin
    bus.op_ready = 1'b0;
    case (state)
      S_LOAD:  bus.op_ready = has_space;
      S_MAC:   bus.op_ready = 1'b1;
      S_SA:    bus.op_ready = (remaining != '0) && sa_space;
      default: bus.op_ready = 1'b0;
    endcase
  end

  // PE drive: mode follows state, data only passes through on a beat.
  always_comb begin
    bus.pe_mode_o   = 2'd3;
    bus.pe_in_o     = 8'd0;
    bus.pe_filter_o = 8'd0;
    bus.pe_act_o    = 1'b0;
    case (state)
      S_LOAD: begin
        if (fire) begin
          bus.pe_mode_o   = 2'd1;
          bus.pe_in_o     = bus.op_a;
          bus.pe_filter_o = bus.op_b;
        end
      end
      S_MAC, S_DRAIN, S_CAPM: begin
        bus.pe_mode_o = 2'd0;
        if (fire) begin
          bus.pe_in_o     = bus.op_a;
          bus.pe_filter_o = bus.op_b;
          bus.pe_act_o    = 1'b1;
        end
      end
      S_SA: begin
        bus.pe_mode_o = 2'd2;
        if (fire) begin
          bus.pe_in_o     = bus.op_a;
          bus.pe_filter_o = bus.op_b;
          bus.pe_act_o    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Result capture: which state pushes what into the FIFO.
  always_comb begin
    push      = 1'b0;
    push_data = 8'd0;
    push_last = 1'b0;
    case (state)
      S_CAPL, S_CAPM: begin
        push      = has_space;
        push_data = bus.pe_out_i;
        push_last = 1'b1;
      end
      S_SA: begin
        push      = inflight;
        push_data = bus.pe_out_i;
        push_last = inflight_last;
      end
      S_RESP: begin
        push      = has_space;
        push_last = 1'b1;
      end
      default: ;
    endcase
  end

  // Operation sequencer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      remaining     <= '0;
      drain_cnt     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            remaining     <= bus.cmd_len;
            drain_cnt     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            case (bus.cmd_op)
              2'd0:    state <= (bus.cmd_len == '0) ? S_RESP : S_MAC;
              2'd2:    state <= (bus.cmd_len == '0) ? S_RESP : S_SA;
              default: state <= S_LOAD;
            endcase
          end
        end
        S_LOAD: if (fire) state <= S_CAPL;
        S_CAPL: if (push) state <= S_IDLE;
        S_MAC: begin
          if (fire) begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) state <= (ACC_LAT == 0) ? S_CAPM : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_END) state <= S_CAPM;
          else drain_cnt <= drain_cnt + DW'(1);
        end
        S_CAPM: if (push) state <= S_IDLE;
        S_SA: begin
          inflight <= fire;
          if (fire) begin
            remaining     <= remaining - LEN_W'(1);
            inflight_last <= (remaining == LEN_W'(1));
          end
          if (inflight && inflight_last) state <= S_IDLE;
        end
        S_RESP: if (push) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are meaningless until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_last, push_data};
  end

  assign bus.res_valid = (count != '0);
  assign bus.res_data  = bus.res_valid ? mem[rd_ptr][7:0] : 8'd0;
  assign bus.res_last  = bus.res_valid ? mem[rd_ptr][8]   : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_pe_seq.sv
`default_nettype none
// ============================================================================
// Module     : tb_pe_seq
// Description: Self-checking bench for pe_seq with a behavioural PE and a
//              result scoreboard.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_pe_seq;
  localparam int LEN_W   = 4;
  localparam int ACC_LAT = 1;
  localparam int FIFO_D  = 2;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pe_seq_if #(.LEN_W(LEN_W)) bus ();

  pe_seq #(.LEN_W(LEN_W), .ACC_LAT(ACC_LAT), .FIFO_D(FIFO_D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural PE: registered output, weight store, accumulator, SA pass.
  logic [7:0] pe_w   = 8'd0;
  logic [7:0] pe_acc = 8'd0;
  logic [7:0] pe_out = 8'd0;
  assign bus.pe_out_i = pe_out;

  always @(posedge clk) begin
    case (bus.pe_mode_o)
      2'd0: begin
        if (bus.pe_act_o) begin
          pe_acc <= pe_acc + bus.pe_in_o * bus.pe_filter_o;
          pe_out <= pe_acc + bus.pe_in_o * bus.pe_filter_o;
        end else begin
          pe_out <= pe_acc;
        end
      end
      2'd1: begin
        pe_w   <= bus.pe_filter_o;
        pe_out <= bus.pe_filter_o;
      end
      2'd2: if (bus.pe_act_o) pe_out <= bus.pe_in_o * pe_w + bus.pe_filter_o;
      default: pe_acc <= 8'd0;
    endcase
  end

  res_t       exp_q[$];
  int         passed = 0;
  int         total  = 0;
  logic [7:0] model_w = 8'd0;
  int         cyc = 0, last_pop = 0, prev_pop = 0;
  int         n_mode1 = 0, n_len0_viol = 0;
  logic       win_len0 = 1'b0;
  logic       chk_bubble = 1'b0;
  logic       rr_rand = 1'b0;
  logic       rr_val  = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: pops an expectation for every accepted result.
  task automatic monitor_loop();
    res_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (bus.pe_mode_o == 2'd1) n_mode1++;
        if (win_len0 && (bus.op_ready || bus.pe_act_o)) n_len0_viol++;
        if (bus.res_valid && bus.res_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_result: got 0x%0h, expected no result", bus.res_data);
          end else begin
            e = exp_q.pop_front();
            check("res_data", {24'd0, bus.res_data}, {24'd0, e.d});
            check("res_last", {31'd0, bus.res_last}, {31'd0, e.l});
          end
          prev_pop = last_pop;
          last_pop = cyc;
        end
      end
    end
  endtask

  task automatic ready_loop();
    forever begin
      bus.res_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_val;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      if (chk_bubble) begin
        check("bubble_act", {31'd0, bus.pe_act_o}, 32'd0);
        check("bubble_mode", {30'd0, bus.pe_mode_o}, 32'd0);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input int len);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = LEN_W'(len);
    @(negedge clk);
    while (!bus.cmd_ready && n < 300) begin @(negedge clk); n++; end
    if (!bus.cmd_ready) begin
      total++;
      $display("FAIL cmd_timeout: got cmd_ready=0 after %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] a, input logic [7:0] b,
                           output logic [1:0] m, output logic [7:0] f, output logic ac);
    int n = 0;
    bus.op_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    @(negedge clk);
    while (!bus.op_ready && n < 300) begin @(negedge clk); n++; end
    if (!bus.op_ready) begin
      total++;
      $display("FAIL beat_timeout: got op_ready=0 after %0d cycles, expected 1", n);
    end
    m  = bus.pe_mode_o;
    f  = bus.pe_filter_o;
    ac = bus.pe_act_o;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    check("drain_left", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [1:0] m, output logic [7:0] f, output logic ac);
    res_t e;
    e.d = b; e.l = 1'b1;
    exp_q.push_back(e);
    model_w = b;
    send_cmd(op, int'($urandom_range(0, 15)));
    send_beat(a, b, m, f, ac);
  endtask

  // Expected MAC result is the truncated dot product; the PE starts cleared.
  task automatic do_mac(input int len, input logic [7:0] as[16], input logic [7:0] bs[16],
                        input int bub[16]);
    res_t e;
    logic [7:0] sum;
    logic [1:0] m; logic [7:0] f; logic ac;
    sum = 8'd0;
    for (int i = 0; i < len; i++) sum = sum + as[i] * bs[i];
    e.d = sum; e.l = 1'b1;
    exp_q.push_back(e);
    send_cmd(2'd0, len);
    for (int i = 0; i < len; i++) begin
      send_beat(as[i], bs[i], m, f, ac);
      if (i < len - 1) idle(bub[i]);
    end
  endtask

  // Each SA result is a*w + b with the last loaded weight.
  task automatic do_sa(input int len, input logic [7:0] as[16], input logic [7:0] bs[16],
                       input int bub[16]);
    res_t e;
    logic [1:0] m; logic [7:0] f; logic ac;
    if (len == 0) begin
      e.d = 8'd0; e.l = 1'b1;
      exp_q.push_back(e);
    end
    for (int i = 0; i < len; i++) begin
      e.d = as[i] * model_w + bs[i];
      e.l = (i == len - 1);
      exp_q.push_back(e);
    end
    send_cmd(2'd2, len);
    for (int i = 0; i < len; i++) begin
      send_beat(as[i], bs[i], m, f, ac);
      if (i < len - 1) idle(bub[i]);
    end
  endtask

  initial begin
    logic [7:0] as[16];
    logic [7:0] bs[16];
    int         bub[16];
    logic [1:0] m; logic [7:0] f; logic ac;
    int         viol;

    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_len = '0;
    bus.op_valid  = 1'b0; bus.op_a = 8'd0;   bus.op_b = 8'd0;
    for (int i = 0; i < 16; i++) begin as[i] = 8'd0; bs[i] = 8'd0; bub[i] = 0; end

    fork
      monitor_loop();
      ready_loop();
    join_none

    // Reset values.
    @(negedge clk);
    check("rst_mode", {30'd0, bus.pe_mode_o}, 32'd3);
    check("rst_in", {24'd0, bus.pe_in_o}, 32'd0);
    check("rst_filter", {24'd0, bus.pe_filter_o}, 32'd0);
    check("rst_act", {31'd0, bus.pe_act_o}, 32'd0);
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("rst_op_ready", {31'd0, bus.op_ready}, 32'd0);
    check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rst_res_data", {24'd0, bus.res_data}, 32'd0);
    check("rst_res_last", {31'd0, bus.res_last}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    @(posedge clk); #1;

    // LOAD 0x05.
    n_mode1 = 0;
    do_load(2'd1, 8'h3C, 8'h05, m, f, ac);
    check("load_mode", {30'd0, m}, 32'd1);
    check("load_filter", {24'd0, f}, 32'h05);
    check("load_act", {31'd0, ac}, 32'd0);
    wait_drain();
    check("load_mode1_cycles", n_mode1, 32'd1);
    check("load_busy_after", {31'd0, bus.busy}, 32'd0);

    // SA len 2 back-to-back with weight 5: 0x11 then 0x15.
    as[0] = 8'd3; bs[0] = 8'd2; as[1] = 8'd4; bs[1] = 8'd1; bub[0] = 0;
    do_sa(2, as, bs, bub);
    wait_drain();
    check("sa_consecutive", last_pop - prev_pop, 32'd1);

    // MAC len 3 with two bubbles between beats 2 and 3: 0x1B.
    as[0] = 8'd2; bs[0] = 8'd3; as[1] = 8'd4; bs[1] = 8'd5; as[2] = 8'd1; bs[2] = 8'd1;
    bub[0] = 0; bub[1] = 2;
    chk_bubble = 1'b1;
    do_mac(3, as, bs, bub);
    chk_bubble = 1'b0;
    wait_drain();

    // SA len 4 with a stalled consumer: only two beats get in.
    rr_val = 1'b0;
    idle(1);
    for (int i = 0; i < 4; i++) begin as[i] = 8'($urandom_range(0, 255)); bs[i] = 8'($urandom_range(0, 255)); end
    begin
      res_t e;
      for (int i = 0; i < 4; i++) begin
        e.d = as[i] * model_w + bs[i];
        e.l = (i == 3);
        exp_q.push_back(e);
      end
    end
    send_cmd(2'd2, 4);
    send_beat(as[0], bs[0], m, f, ac);
    send_beat(as[1], bs[1], m, f, ac);
    bus.op_valid = 1'b1; bus.op_a = as[2]; bus.op_b = bs[2];
    viol = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.op_ready) viol++;
      @(posedge clk); #1;
    end
    check("sa_stall_op_ready", viol, 32'd0);
    rr_val = 1'b1;
    send_beat(as[2], bs[2], m, f, ac);
    send_beat(as[3], bs[3], m, f, ac);
    wait_drain();

    // Reset in the middle of a MAC.
    send_cmd(2'd0, 3);
    send_beat(8'd9, 8'd9, m, f, ac);
    send_beat(8'd7, 8'd3, m, f, ac);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_mode", {30'd0, bus.pe_mode_o}, 32'd3);
    check("midrst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    @(posedge clk); #1;
    do_load(2'd3, 8'h00, 8'h07, m, f, ac);
    wait_drain();

    // MAC len 0: no operand handshake, no activate, one zero result.
    n_len0_viol = 0;
    win_len0 = 1'b1;
    do_mac(0, as, bs, bub);
    wait_drain();
    win_len0 = 1'b0;
    check("len0_no_beat", n_len0_viol, 32'd0);

    // Random command mix with random consumer back-pressure.
    rr_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int op  = int'($urandom_range(0, 3));
      int len = int'($urandom_range(0, 5));
      for (int i = 0; i < 16; i++) begin
        as[i]  = 8'($urandom_range(0, 255));
        bs[i]  = 8'($urandom_range(0, 255));
        bub[i] = int'($urandom_range(0, 2));
      end
      case (op)
        0:       do_mac(len, as, bs, bub);
        2:       do_sa(len, as, bs, bub);
        default: do_load(2'(op), as[0], bs[0], m, f, ac);
      endcase
    end
    rr_rand = 1'b0;
    rr_val  = 1'b1;
    wait_drain();
    check("final_busy", {31'd0, bus.busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pe_seq.md
Name: pe_seq

Overview:
- Command-driven initiator that drives one processing element's control and data inputs (mode, input, filter, activate) and collects its pe_out return.
- Sequences three operations: weight LOAD (save mode), MAC (single mode) and SA pass (sa mode).
- Returns results on a valid/ready stream.
- Sits between the array controller / operand buffers and a PE column head.

Parameters:
LEN_W, 4, width of command beat count
ACC_LAT, 1, drain cycles after the last MAC beat before pe_out_i is sampled
FIFO_D, 2, result FIFO depth, power of two, >=2

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_op  in  2  0=MAC, 1=LOAD, 2=SA, 3=reserved (treated as LOAD)
cmd_len  in  LEN_W  beat count for MAC/SA; ignored for LOAD
op_valid  in  1  operand beat offered
op_ready  out  1  operand beat accepted when op_valid&&op_ready
op_a  in  8  activation (to pe_in_o)
op_b  in  8  filter/weight/addend (to pe_filter_o)
pe_mode_o  out  2  PE mode: 0 single, 1 save, 2 sa, 3 initial
pe_in_o  out  8  PE input data
pe_filter_o  out  8  PE filter data
pe_act_o  out  1  PE activate
pe_out_i  in  8  PE result return
res_valid  out  1  result available (FIFO not empty)
res_ready  in  1  result consumed when res_valid&&res_ready
res_data  out  8  result value
res_last  out  1  final result of current command
busy  out  1  state != IDLE or FIFO not empty

Behaviour:
- Reset: state IDLE, FIFO empty, in-flight cleared.
- Reset output values: pe_mode_o=3, pe_in_o=0, pe_filter_o=0, pe_act_o=0, cmd_ready=0 while rst=0 (then 1 in IDLE), op_ready=0, res_valid=0, res_data=0, res_last=0, busy=0.
- Reset mid-operation aborts the command and drops FIFO contents; no partial result is emitted.
- PE drive outputs are combinational from state, and from op_a/op_b gated by the beat fire.
- IDLE: drive mode 3, zero data. On cmd_valid, latch op and len, set remaining count, then go to:
  - LOAD for cmd_op 1 or 3;
  - MAC for cmd_op 0;
  - SA for cmd_op 2;
  - RESP if cmd_len==0 on MAC/SA.
- LOAD:
  - op_ready=1 iff FIFO has space.
  - On the beat: mode 1, pe_filter_o=op_b, pe_in_o=op_a, act 0.
  - Next cycle (CAPL): mode 3, capture pe_out_i (the stored weight) into FIFO with last=1, then go to IDLE.
  - Before the beat: mode 3.
- MAC:
  - op_ready=1.
  - Beat: mode 0, pe_in_o=op_a, pe_filter_o=op_b, act 1.
  - Bubble (no op_valid): mode 0, pe_in_o=0, pe_filter_o=0, act 0, so the product is zero.
  - After the final beat, go to DRAIN.
- DRAIN: bubble drive for ACC_LAT cycles, then CAPM.
- CAPM:
  - Wait for FIFO space while still bubble-driving mode 0.
  - Push pe_out_i with last=1, then go to IDLE.
  - Accumulator clearing is PE-side; pe_seq never clears it.
- SA:
  - op_ready=1 iff (fifo_count + inflight) < FIFO_D.
  - Beat: mode 2, pe_in_o=op_a, pe_filter_o=op_b, act 1; set inflight, tagged last if it is the final beat.
  - Bubble: mode 2, act 0, zero data.
  - On the cycle after each beat, push pe_out_i with its tag.
  - Once the final beat's result is pushed, go to IDLE.
  - Back-to-back beats deliver one result per cycle.
- RESP (len 0): push res_data=0 with last=1 when FIFO has space, then go to IDLE.
- FIFO:
  - FIFO_D entries of {data, last}.
  - Simultaneous push and pop when full is not possible, because space is checked before issue.
  - Simultaneous push and pop at other occupancies keeps the count unchanged.
  - res_data and res_last come from the head entry; both are 0 when empty.
- A new command cannot start until IDLE. Results of a prior command may still drain from the FIFO while the next command runs; ordering is preserved.
- All arithmetic (8-bit truncation) is PE-side; pe_seq is pass-through.

Test Plan:
- LOAD op_b=0x05 -> exactly one cycle with pe_mode_o=1 and pe_filter_o=0x05; then one result res_data=0x05, res_last=1; busy falls after the pop.
- After LOAD 0x05, SA len=2 with beats (a=3,b=2),(a=4,b=1) back-to-back -> results 0x11 then 0x15 on consecutive cycles; res_last only on 0x15.
- MAC len=3 with beats (2,3),(4,5),(1,1), bubbles between beats 2 and 3, starting from a cleared accumulator -> single result 0x1B with last=1; act 0 during bubbles.
- SA len=4 with res_ready=0 -> op_ready drops after 2 accepted beats; release res_ready -> 4 results in order, none lost.
- Deassert rst mid-MAC (after beat 2) -> mode 3, FIFO empty, cmd_ready=1 after release; the next LOAD 0x07 returns 0x07.
- MAC cmd_len=0 -> no op_ready, no act; one result 0x00 with last=1.
